// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the 5-stage MIPS core.
// Detects load-use hazards and honours execute hold and branch flush.
module id_ex_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUCTL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_d,
  input  logic                RegWriteD,
  input  logic                MemToRegD,
  input  logic                MemWriteD,
  input  logic                ALUSrcD,
  input  logic                RegDstD,
  input  logic                BranchD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic [DATA_W-1:0]   RD1D,
  input  logic [DATA_W-1:0]   RD2D,
  input  logic [REG_AW-1:0]   RsD,
  input  logic [REG_AW-1:0]   RtD,
  input  logic [REG_AW-1:0]   RdD,
  input  logic [DATA_W-1:0]   SignImmD,
  input  logic [DATA_W-1:0]   PCPlus4D,
  input  logic                flush_e,
  input  logic                hold_e,
  output logic                valid_e,
  output logic                RegWriteE,
  output logic                MemToRegE,
  output logic                MemWriteE,
  output logic                ALUSrcE,
  output logic                RegDstE,
  output logic                BranchE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic [DATA_W-1:0]   RD1E,
  output logic [DATA_W-1:0]   RD2E,
  output logic [REG_AW-1:0]   RsE,
  output logic [REG_AW-1:0]   RtE,
  output logic [REG_AW-1:0]   RdE,
  output logic [DATA_W-1:0]   SignImmE,
  output logic [DATA_W-1:0]   PCPlus4E,
  output logic                stall_d
);

  logic load_use;

  // A load writing $0 can never feed a dependent instruction, so RtE==0 is excluded.
  assign load_use = valid_e & MemToRegE & RegWriteE & valid_d & (RtE != '0) &
                    ((RtE == RsD) | (RtE == RtD));

  assign stall_d = hold_e | (load_use & ~flush_e);

  // Flush beats hold; a load-use bubble only applies when E is free to advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e     <= 1'b0;
      RegWriteE   <= 1'b0;
      MemToRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      RsE         <= '0;
      RtE         <= '0;
      RdE         <= '0;
      SignImmE    <= '0;
      PCPlus4E    <= '0;
    end else if (flush_e || (!hold_e && load_use)) begin
      valid_e     <= 1'b0;
      RegWriteE   <= 1'b0;
      MemToRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      RsE         <= '0;
      RtE         <= '0;
      RdE         <= '0;
      SignImmE    <= '0;
      PCPlus4E    <= '0;
    end else if (!hold_e) begin
      // An empty decode slot must not carry live control into execute.
      valid_e     <= valid_d;
      RegWriteE   <= valid_d & RegWriteD;
      MemToRegE   <= valid_d & MemToRegD;
      MemWriteE   <= valid_d & MemWriteD;
      ALUSrcE     <= valid_d & ALUSrcD;
      RegDstE     <= valid_d & RegDstD;
      BranchE     <= valid_d & BranchD;
      ALUControlE <= valid_d ? ALUControlD : '0;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= RdD;
      SignImmE    <= SignImmD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule
